// File: rtl/ushift_if.sv
// Handshake/data bundle for ushift_burst.
// The rot signal exists only when ROTATE_EN is defined.
interface ushift_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic [1:0]       mode;
   logic             s_in_r;
   logic             s_in_l;
   logic [WIDTH-1:0] p_in;
   logic             start;
   logic [CNT_W-1:0] burst_len;
`ifdef ROTATE_EN
   logic             rot;
`endif
   logic [WIDTH-1:0] q;
   logic             s_out_r;
   logic             s_out_l;
   logic             busy;
   logic             done;

   modport master (
      output mode, s_in_r, s_in_l, p_in, start, burst_len,
`ifdef ROTATE_EN
      output rot,
`endif
      input  q, s_out_r, s_out_l, busy, done
   );

   modport slave (
      input  mode, s_in_r, s_in_l, p_in, start, burst_len,
`ifdef ROTATE_EN
      input  rot,
`endif
      output q, s_out_r, s_out_l, busy, done
   );
endinterface

// File: rtl/ushift_burst.sv
// Universal shift register with an automatic N-shift burst engine.
// Define ROTATE_EN to add the rot input (shifts recirculate the exiting bit).
module ushift_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input logic    clk,
   input logic    clear_b,
   ushift_if.slave bus
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [0:0]       state;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;
   logic             dir_l;
   logic             done;
   logic             rot;
   logic [WIDTH-1:0] q_sr;
   logic [WIDTH-1:0] q_sl;

`ifdef ROTATE_EN
   assign rot = bus.rot;
`else
   assign rot = 1'b0;
`endif

   assign q_sr = {(rot ? q[0] : bus.s_in_r), q[WIDTH-1:1]};
   assign q_sl = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : bus.s_in_l)};

   always_ff @(posedge clk or negedge clear_b) begin
      if (!clear_b) begin
         state <= IDLE;
         q     <= '0;
         cnt   <= '0;
         dir_l <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // start wins over mode; q holds on the accepting edge
               if (bus.start) begin
                  if (bus.burst_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     cnt   <= bus.burst_len;
                     dir_l <= (bus.mode == 2'b10);
                     state <= BURST;
                  end
               end else begin
                  case (bus.mode)
                     2'b01:   q <= q_sr;
                     2'b10:   q <= q_sl;
                     2'b11:   q <= bus.p_in;
                     default: q <= q;
                  endcase
               end
            end
            BURST: begin
               q   <= dir_l ? q_sl : q_sr;
               cnt <= cnt - ONE;
               if (cnt == ONE) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.q       = q;
   assign bus.s_out_r = q[0];
   assign bus.s_out_l = q[WIDTH-1];
   assign bus.busy    = (state == BURST);
   assign bus.done    = done;
endmodule
